cond_status_unit: RTL and testbench

Consumer end of the ALU flag interface. Holds the architectural NZCV status flags written by the ALU and returns the registered carry to the ALU carry input. Evaluates the 4-bit ARM condition field of the instruction currently in the control unit and returns a registered pass/fail result. Keeps saturating pass/fail event counters for debug. Sits between the ALU and the control unit in the data path.

---
 rtl/cond_status_unit_pkg.sv | 36 +++
 rtl/cond_status_unit_cond_decode.sv | 46 ++++
 rtl/cond_status_unit.sv | 95 +++++++++
 tb/tb_cond_status_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_status_unit_pkg.sv
// Shared definitions for the status-flag / condition-evaluation slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cond_status_unit_pkg;

  // NZCV bit positions, shared with the ALU flag output.
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  // ARM condition field encodings (IR[31:28]).
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Result FSM: RESULT marks the cycle the registered outcome is valid.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } res_state_t;

endpackage

// File: rtl/cond_status_unit_cond_decode.sv
// Combinational ARM condition decode: (cond, nzcv) -> pass.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module cond_decode
  import cond_status_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Map each condition code to its flag predicate; NV never executes.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_status_unit.sv
// Holds NZCV flags, returns carry to the ALU, evaluates condition codes, counts pass/fail.
// Latency: cond_valid/cond_pass one cycle after eval; flags_q one cycle after flags_we.
// Backpressure: none; eval accepted every cycle.
module cond_status_unit
  import cond_status_unit_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       flags_in,
  input  logic             flags_we,
  input  logic [3:0]       cond,
  input  logic             eval,
  output logic             cond_valid,
  output logic             cond_pass,
  output logic [3:0]       flags_q,
  output logic             c_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  res_state_t state_q;
  res_state_t state_d;
  logic [3:0] flags_eff;
  logic       dec_pass;

  // Same-cycle flag write is visible to the evaluation only when bypass is enabled.
  assign flags_eff = (BYPASS && flags_we) ? flags_in : flags_q;
  assign c_out     = flags_q[FLAG_C];

  cond_decode u_cond_decode (
    .cond (cond),
    .nzcv (flags_eff),
    .pass (dec_pass)
  );

  // Architectural flag register, written on S-bit instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  // Result FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and valid strobe: every eval produces one RESULT cycle.
  always_comb begin
    state_d    = ST_IDLE;
    cond_valid = 1'b0;
    if (eval) begin
      state_d = ST_RESULT;
    end
    if (state_q == ST_RESULT) begin
      cond_valid = 1'b1;
    end
  end

  // Registered pass/fail result, held until the next evaluation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_pass <= 1'b0;
    end else if (eval) begin
      cond_pass <= dec_pass;
    end
  end

  // Saturating debug counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (eval) begin
      if (dec_pass) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cond_status_unit.sv
// Bench for cond_status_unit: default, no-bypass and 2-bit-counter instances share stimulus.
// Latency: expects results one cycle after each driven step.
// Backpressure: none exercised (the design has none).
module tb_cond_status_unit;

  logic       clk;
  logic       reset;
  logic [3:0] flags_in;
  logic       flags_we;
  logic [3:0] cond;
  logic       eval;

  // Default instance: BYPASS=1, CNT_W=16.
  logic        a_valid, a_pass, a_cout;
  logic [3:0]  a_flags;
  logic [15:0] a_pcnt, a_fcnt;
  // No-bypass instance.
  logic        b_valid, b_pass, b_cout;
  logic [3:0]  b_flags;
  logic [15:0] b_pcnt, b_fcnt;
  // Narrow counter instance: BYPASS=1, CNT_W=2.
  logic        s_valid, s_pass, s_cout;
  logic [3:0]  s_flags;
  logic [1:0]  s_pcnt, s_fcnt;

  int total;
  int bad;

  typedef struct {
    logic        vld;
    logic        pa;
    logic        pb;
    logic [3:0]  fl;
    logic [15:0] pca;
    logic [15:0] fca;
    logic [15:0] pcb;
    logic [15:0] fcb;
    logic [1:0]  pcs;
    logic [1:0]  fcs;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic [3:0]  m_flags;
  logic        m_vld, m_pa, m_pb;
  logic [15:0] m_pca, m_fca, m_pcb, m_fcb;
  logic [1:0]  m_pcs, m_fcs;

  cond_status_unit #(.BYPASS(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
    .cond(cond), .eval(eval), .cond_valid(a_valid), .cond_pass(a_pass),
    .flags_q(a_flags), .c_out(a_cout), .pass_cnt(a_pcnt), .fail_cnt(a_fcnt)
  );

  cond_status_unit #(.BYPASS(1'b0), .CNT_W(16)) u_nb (
    .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
    .cond(cond), .eval(eval), .cond_valid(b_valid), .cond_pass(b_pass),
    .flags_q(b_flags), .c_out(b_cout), .pass_cnt(b_pcnt), .fail_cnt(b_fcnt)
  );

  cond_status_unit #(.BYPASS(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
    .cond(cond), .eval(eval), .cond_valid(s_valid), .cond_pass(s_pass),
    .flags_q(s_flags), .c_out(s_cout), .pass_cnt(s_pcnt), .fail_cnt(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: pairs of codes share a base predicate, odd codes invert it.
  function automatic logic ref_dec(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the model, push the expectation,
  // then pop it and compare once the clock edge has been taken.
  task automatic step(input logic rst, input logic we, input logic [3:0] fin,
                      input logic ev, input logic [3:0] cnd);
    exp_t e;
    exp_t g;
    logic [3:0] fa;
    logic pa, pb;
    reset    = rst;
    flags_we = we;
    flags_in = fin;
    eval     = ev;
    cond     = cnd;
    if (rst) begin
      m_flags = 4'b0000;
      m_vld = 1'b0; m_pa = 1'b0; m_pb = 1'b0;
      m_pca = '0; m_fca = '0; m_pcb = '0; m_fcb = '0; m_pcs = '0; m_fcs = '0;
    end else begin
      fa = we ? fin : m_flags;
      m_vld = ev;
      if (ev) begin
        pa = ref_dec(cnd, fa);
        pb = ref_dec(cnd, m_flags);
        m_pa = pa;
        m_pb = pb;
        if (pa) begin
          if (m_pca != 16'hFFFF) m_pca = m_pca + 16'd1;
          if (m_pcs != 2'd3) m_pcs = m_pcs + 2'd1;
        end else begin
          if (m_fca != 16'hFFFF) m_fca = m_fca + 16'd1;
          if (m_fcs != 2'd3) m_fcs = m_fcs + 2'd1;
        end
        if (pb) m_pcb = m_pcb + 16'd1;
        else    m_fcb = m_fcb + 16'd1;
      end
      if (we) m_flags = fin;
    end
    e.vld = m_vld; e.pa = m_pa; e.pb = m_pb; e.fl = m_flags;
    e.pca = m_pca; e.fca = m_fca; e.pcb = m_pcb; e.fcb = m_fcb;
    e.pcs = m_pcs; e.fcs = m_fcs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk("a_valid",  32'(a_valid), 32'(g.vld));
    chk("a_pass",   32'(a_pass),  32'(g.pa));
    chk("a_flags",  32'(a_flags), 32'(g.fl));
    chk("a_cout",   32'(a_cout),  32'(g.fl[1]));
    chk("a_pcnt",   32'(a_pcnt),  32'(g.pca));
    chk("a_fcnt",   32'(a_fcnt),  32'(g.fca));
    chk("b_valid",  32'(b_valid), 32'(g.vld));
    chk("b_pass",   32'(b_pass),  32'(g.pb));
    chk("b_flags",  32'(b_flags), 32'(g.fl));
    chk("b_pcnt",   32'(b_pcnt),  32'(g.pcb));
    chk("b_fcnt",   32'(b_fcnt),  32'(g.fcb));
    chk("s_valid",  32'(s_valid), 32'(g.vld));
    chk("s_pass",   32'(s_pass),  32'(g.pa));
    chk("s_cout",   32'(s_cout),  32'(g.fl[1]));
    chk("s_pcnt",   32'(s_pcnt),  32'(g.pcs));
    chk("s_fcnt",   32'(s_fcnt),  32'(g.fcs));
  endtask

  initial begin
    logic [3:0] sweep_flags [4];
    total = 0;
    bad   = 0;
    sweep_flags[0] = 4'b0000;
    sweep_flags[1] = 4'b0100;
    sweep_flags[2] = 4'b1001;
    sweep_flags[3] = 4'b0010;
    reset = 1'b1; flags_we = 1'b0; flags_in = 4'b0000; eval = 1'b0; cond = 4'b0000;

    // Reset for two cycles while trying to write flags and evaluate.
    step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1110);
    step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1110);
    // Quiet cycle: nothing valid, held result is 0.
    step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // Flag write with carry set; c_out follows flags_q.
    step(1'b0, 1'b1, 4'b0110, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // Full decode sweep, 16 back-to-back evals per flag pattern.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, sweep_flags[k], 1'b0, 4'b0000);
      for (int c = 0; c < 16; c++) begin
        step(1'b0, 1'b0, 4'b0000, 1'b1, 4'(c));
      end
    end
    // Result must hold through an idle cycle.
    step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // Bypass: flags 0000 held, then Z written with EQ evaluated in the same cycle.
    step(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // Saturation from a clean reset: 5 AL evals then 5 NV evals.
    step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1110);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111);

    // Mid-stream reset during back-to-back evals, then recovery.
    step(1'b0, 1'b1, 4'b1001, 1'b1, 4'b1100);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1011);
    step(1'b1, 1'b1, 4'b0110, 1'b1, 4'b1110);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // Short random tail for mixed writes and evals.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
